// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker.
//   state_t        : checker FSM states (DATA -> PARITY -> HOLD -> DATA)
//   PARITY_EVEN    : parity-sense select value for even parity
//   PARITY_ODD_SEL : parity-sense select value for odd parity
package parity_pkg;

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_PARITY = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic PARITY_EVEN    = 1'b0;
    localparam logic PARITY_ODD_SEL = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator holding the running parity of the current frame.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (parity -> 0)
//   clear  : synchronous clear, takes priority over enable
//   en     : fold bit_in into the running parity this cycle
//   bit_in : serial bit to accumulate
//   parity : XOR of every bit folded in since the last clear/reset
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic parity
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (clear) begin
            parity <= 1'b0;
        end else if (en) begin
            parity <= parity ^ bit_in;
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker: receives DATA_BITS data bits (LSB first) followed by
// one parity bit, reassembles the word and flags frames whose parity is wrong.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   clr           : synchronous abort of a partial frame (ignored in HOLD)
//   s_valid/s_ready/s_data       : serial bit input port
//   m_valid/m_ready/m_data       : reassembled word output port
//   m_parity_err  : frame failed the parity check (valid with m_valid)
//   err_count     : saturating count of failed frames
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits on ready, and ready (s_ready) depends on state only.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 s_valid,
    input  logic                 s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_parity_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int               CNT_W    = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0) ? PARITY_ODD_SEL : PARITY_EVEN;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 acc;

    logic in_frame;
    logic bit_take;
    logic frame_abort;
    logic word_done;
    logic bad_state;
    logic parity_now;

    assign in_frame    = (state == ST_DATA) || (state == ST_PARITY);
    assign s_ready     = in_frame;
    // clr beats a bit presented in the same cycle: the bit is dropped.
    assign bit_take    = s_valid && s_ready && !clr;
    assign frame_abort = clr && in_frame;
    assign word_done   = (state == ST_HOLD) && m_ready;
    assign bad_state   = (state != ST_DATA) && (state != ST_PARITY) && (state != ST_HOLD);
    // Error when data bits plus parity bit do not XOR to the expected sense.
    assign parity_now  = acc ^ s_data ^ ODD_BIT;

    parity_acc u_parity_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (frame_abort || word_done || bad_state),
        .en     (bit_take && (state == ST_DATA)),
        .bit_in (s_data),
        .parity (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_DATA;
            cnt          <= '0;
            shreg        <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_parity_err <= 1'b0;
            err_count    <= '0;
        end else begin
            case (state)
                ST_DATA: begin
                    if (frame_abort) begin
                        cnt <= '0;
                    end else if (bit_take) begin
                        shreg[cnt] <= s_data;
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= ST_PARITY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (frame_abort) begin
                        cnt   <= '0;
                        state <= ST_DATA;
                    end else if (bit_take) begin
                        m_data       <= shreg;
                        m_parity_err <= parity_now;
                        if (parity_now && (err_count != {ERR_CNT_W{1'b1}})) begin
                            err_count <= err_count + 1'b1;
                        end
                        m_valid <= 1'b1;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // The pending word is only released by the handshake.
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_DATA;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    cnt     <= '0;
                    state   <= ST_DATA;
                end
            endcase
        end
    end

endmodule
